// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the sweeper and whatever drives/observes it:
// the control inputs, the function-under-test output, the generated
// stimulus and the result fields.
interface truth_table_sweeper_if;
    logic        start;
    logic        abort;
    logic        x_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic        first_err_valid;

    // Controller / board side: issues commands and supplies x_in.
    modport master (
        output start, abort, x_in,
        input  a, b, c, d, busy, done, pass,
        input  table_out, err_count, first_err_idx, first_err_valid
    );

    // Sweeper side.
    modport slave (
        input  start, abort, x_in,
        output a, b, c, d, busy, done, pass,
        output table_out, err_count, first_err_idx, first_err_valid
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks a 4-input function block through all 16
// input combinations, samples its output after a settle time, and
// compares the measured table against EXPECTED.
module truth_table_sweeper #(
    parameter int          SETTLE_CYC = 2,
    parameter logic [15:0] EXPECTED   = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t      state, state_n;
    logic [3:0]  idx, idx_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  stim, stim_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic        pass, pass_n;
    logic [15:0] table_r, table_n;
    logic [4:0]  err, err_n;
    logic [3:0]  first_idx, first_idx_n;
    logic        first_valid, first_valid_n;
    logic        mismatch;

    // Every output is a register, so the comb block computes the next
    // value of the whole register set and this block just latches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            stim        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            table_r     <= '0;
            err         <= '0;
            first_idx   <= '0;
            first_valid <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            stim        <= stim_n;
            busy        <= busy_n;
            done        <= done_n;
            pass        <= pass_n;
            table_r     <= table_n;
            err         <= err_n;
            first_idx   <= first_idx_n;
            first_valid <= first_valid_n;
        end
    end

    // Next-state logic. Abort beats sampling; pass is decided on the edge
    // into DONE from the error count that already includes index 15.
    always_comb begin
        state_n       = state;
        idx_n         = idx;
        cnt_n         = cnt;
        stim_n        = stim;
        busy_n        = busy;
        done_n        = 1'b0;
        pass_n        = pass;
        table_n       = table_r;
        err_n         = err;
        first_idx_n   = first_idx;
        first_valid_n = first_valid;
        mismatch      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_n         = '0;
                    table_n       = '0;
                    err_n         = '0;
                    first_idx_n   = '0;
                    first_valid_n = 1'b0;
                    pass_n        = 1'b0;
                    cnt_n         = SETTLE_LOAD;
                    stim_n        = '0;
                    busy_n        = 1'b1;
                    state_n       = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    stim_n  = '0;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else if (cnt == 4'd0) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    stim_n  = '0;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else begin
                    table_n[idx] = bus.x_in;
                    mismatch     = (bus.x_in != EXPECTED[idx]);
                    err_n        = err + 5'(mismatch);
                    if (mismatch && !first_valid) begin
                        first_idx_n   = idx;
                        first_valid_n = 1'b1;
                    end
                    if (idx == 4'd15) begin
                        state_n = DONE;
                        stim_n  = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == 5'd0);
                    end else begin
                        idx_n   = idx + 4'd1;
                        stim_n  = idx + 4'd1;
                        cnt_n   = SETTLE_LOAD;
                        state_n = SETTLE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.a               = stim[3];
    assign bus.b               = stim[2];
    assign bus.c               = stim[1];
    assign bus.d               = stim[0];
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.pass            = pass;
    assign bus.table_out       = table_r;
    assign bus.err_count       = err;
    assign bus.first_err_idx   = first_idx;
    assign bus.first_err_valid = first_valid;

endmodule
